// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory stage: store encodings, MMIO map and STATUS layout.
package riscv_mem_pkg;
    typedef enum logic [1:0] {
        ST_B    = 2'b00,
        ST_H    = 2'b01,
        ST_W    = 2'b10,
        ST_NONE = 2'b11
    } storetype_e;

    // Addr[31:5] value selecting the 32-byte MMIO window at 0x8000_0000
    localparam logic [26:0] MMIO_BASE = 27'h400_0000;

    localparam logic [2:0] OFF_GPIO_OUT  = 3'd0;
    localparam logic [2:0] OFF_GPIO_IN   = 3'd1;
    localparam logic [2:0] OFF_CYCLE_LO  = 3'd2;
    localparam logic [2:0] OFF_CYCLE_HI  = 3'd3;
    localparam logic [2:0] OFF_TIMER_CMP = 3'd4;
    localparam logic [2:0] OFF_STATUS    = 3'd5;

    localparam int STATUS_PEND     = 0;
    localparam int STATUS_EN       = 1;
    localparam int STATUS_MISALIGN = 2;
endpackage

// File: rtl/dmem_ram.sv
// Word-indexed data RAM with per-byte write enables, asynchronous read and synchronous write.
module dmem_ram #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            // one array per byte lane keeps each lane's write port independent
            logic [7:0] lane_mem [DEPTH_WORDS];

            always_ff @(posedge clk) begin
                if (we && be[gi]) begin
                    lane_mem[idx] <= wdata[gi*8 +: 8];
                end
            end

            assign rdata[gi*8 +: 8] = lane_mem[idx];
        end
    endgenerate
endmodule

// File: rtl/dmem_mmio.sv
// Data-side memory stage: RAM plus GPIO, 64-bit cycle counter and compare timer in one address space.
module dmem_mmio
    import riscv_mem_pkg::*;
#(
    parameter int N_Bits      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int GPIO_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_Bits-1:0] Addr,
    input  logic [N_Bits-1:0] WriteData,
    input  logic              MemWrite,
    input  logic [1:0]        Storetype,
    output logic [N_Bits-1:0] ReadData,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              irq_timer
);
    localparam int AW = $clog2(DEPTH_WORDS);

    storetype_e        st;
    logic              is_ram;
    logic              is_mmio;
    logic [2:0]        off;
    logic              misaligned;
    logic [3:0]        be;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic              store_ok;
    logic              ram_we;
    logic              mmio_we;
    logic              misalign_set;

    logic [GPIO_W-1:0] gpio_out_reg;
    logic [GPIO_W-1:0] sync1_reg;
    logic [GPIO_W-1:0] sync2_reg;
    logic [N_Bits-1:0] timer_cmp_reg;
    logic [63:0]       cycle_reg;
    logic              pend_reg, en_reg, misalign_reg, irq_reg;
    logic              pend_next, en_next, misalign_next;

    assign st      = storetype_e'(Storetype);
    assign is_ram  = ~Addr[N_Bits-1];
    assign is_mmio = (Addr[N_Bits-1:5] == MMIO_BASE);
    assign off     = Addr[4:2];

    always_comb begin
        misaligned = 1'b0;
        be         = 4'b0000;
        ram_wdata  = WriteData;
        case (st)
            ST_B: begin
                be        = 4'b0001 << Addr[1:0];
                ram_wdata = {4{WriteData[7:0]}};
            end
            ST_H: begin
                misaligned = Addr[0];
                be         = Addr[1] ? 4'b1100 : 4'b0011;
                ram_wdata  = {2{WriteData[15:0]}};
            end
            ST_W: begin
                misaligned = (Addr[1:0] != 2'b00);
                be         = 4'b1111;
            end
            default: ;
        endcase
    end

    // reset wins over a store in the same cycle
    assign store_ok     = MemWrite && !rst && (st != ST_NONE) && !misaligned;
    assign ram_we       = store_ok && is_ram;
    assign mmio_we      = store_ok && is_mmio && (st == ST_W);
    assign misalign_set = MemWrite && (st != ST_NONE) &&
                          ((is_ram && misaligned) || (is_mmio && (st != ST_W || misaligned)));

    dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (be),
        .idx   (Addr[AW+1:2]),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // a timer match sets pend after any same-cycle W1C, so the set always wins
    always_comb begin
        pend_next     = pend_reg;
        en_next       = en_reg;
        misalign_next = misalign_reg;
        if (mmio_we && off == OFF_STATUS) begin
            if (WriteData[STATUS_PEND])     pend_next     = 1'b0;
            if (WriteData[STATUS_MISALIGN]) misalign_next = 1'b0;
            en_next = WriteData[STATUS_EN];
        end
        if (en_reg && cycle_reg[N_Bits-1:0] == timer_cmp_reg) pend_next = 1'b1;
        if (misalign_set) misalign_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_out_reg  <= '0;
            sync1_reg     <= '0;
            sync2_reg     <= '0;
            timer_cmp_reg <= '0;
            cycle_reg     <= '0;
            pend_reg      <= 1'b0;
            en_reg        <= 1'b0;
            misalign_reg  <= 1'b0;
            irq_reg       <= 1'b0;
        end else begin
            cycle_reg    <= cycle_reg + 64'd1;
            sync1_reg    <= gpio_in;
            sync2_reg    <= sync1_reg;
            pend_reg     <= pend_next;
            en_reg       <= en_next;
            misalign_reg <= misalign_next;
            irq_reg      <= pend_next & en_next;
            if (mmio_we && off == OFF_GPIO_OUT)  gpio_out_reg  <= WriteData[GPIO_W-1:0];
            if (mmio_we && off == OFF_TIMER_CMP) timer_cmp_reg <= WriteData;
        end
    end

    always_comb begin
        ReadData = '0;
        if (is_ram) begin
            ReadData = ram_rdata;
        end else if (is_mmio) begin
            case (off)
                OFF_GPIO_OUT:  ReadData = {{(N_Bits-GPIO_W){1'b0}}, gpio_out_reg};
                OFF_GPIO_IN:   ReadData = {{(N_Bits-GPIO_W){1'b0}}, sync2_reg};
                OFF_CYCLE_LO:  ReadData = cycle_reg[31:0];
                OFF_CYCLE_HI:  ReadData = cycle_reg[63:32];
                OFF_TIMER_CMP: ReadData = timer_cmp_reg;
                OFF_STATUS:    ReadData = {{(N_Bits-3){1'b0}}, misalign_reg, en_reg, pend_reg};
                default:       ReadData = '0;
            endcase
        end
    end

    assign gpio_out  = gpio_out_reg;
    assign irq_timer = irq_reg;
endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: byte-level memory/register model checked every cycle, plus directed literal checks.
module tb_dmem_mmio;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] Addr = '0;
    logic [31:0] WriteData = '0;
    logic        MemWrite = 1'b0;
    logic [1:0]  Storetype = 2'b10;
    logic [31:0] ReadData;
    logic [7:0]  gpio_in = '0;
    logic [7:0]  gpio_out;
    logic        irq_timer;

    localparam logic [31:0] A_GPIO_OUT = 32'h8000_0000;
    localparam logic [31:0] A_GPIO_IN  = 32'h8000_0004;
    localparam logic [31:0] A_CYC_LO   = 32'h8000_0008;
    localparam logic [31:0] A_CYC_HI   = 32'h8000_000C;
    localparam logic [31:0] A_CMP      = 32'h8000_0010;
    localparam logic [31:0] A_STATUS   = 32'h8000_0014;

    int pass_cnt  = 0;
    int check_cnt = 0;

    dmem_mmio dut (
        .clk       (clk),
        .rst       (rst),
        .Addr      (Addr),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .Storetype (Storetype),
        .ReadData  (ReadData),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .irq_timer (irq_timer)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (bytes + register values) ----------------
    logic [7:0]  m_mem [1024];
    bit          m_vld [1024];
    logic [7:0]  m_gpio_out, m_gin_last, m_gin_prev;
    logic [31:0] m_cmp;
    logic [63:0] m_cycle;
    bit          m_pend, m_en, m_mis, model_live;

    always @(posedge clk) begin
        if (rst) begin
            m_gpio_out = '0; m_gin_last = '0; m_gin_prev = '0;
            m_cmp = '0; m_cycle = '0;
            m_pend = 0; m_en = 0; m_mis = 0;
            model_live = 1;
        end else begin
            bit hit;
            int size;
            hit = m_en && (m_cycle[31:0] == m_cmp);
            if (MemWrite && Storetype != 2'b11) begin
                size = 1 << Storetype;
                if (!Addr[31]) begin
                    if (Addr % size == 0) begin
                        for (int k = 0; k < size; k++) begin
                            m_mem[int'(Addr[9:0]) + k] = WriteData[8*k +: 8];
                            m_vld[int'(Addr[9:0]) + k] = 1;
                        end
                    end else m_mis = 1;
                end else if (Addr[31:5] == 27'h400_0000) begin
                    if (size == 4 && Addr[1:0] == 2'b00) begin
                        case (Addr[4:2])
                            3'd0: m_gpio_out = WriteData[7:0];
                            3'd4: m_cmp = WriteData;
                            3'd5: begin
                                if (WriteData[0]) m_pend = 0;
                                if (WriteData[2]) m_mis = 0;
                                m_en = WriteData[1];
                            end
                            default: ;
                        endcase
                    end else m_mis = 1;
                end
            end
            if (hit) m_pend = 1;
            m_cycle = m_cycle + 64'd1;
            m_gin_prev = m_gin_last;
            m_gin_last = gpio_in;
        end
    end

    function automatic logic [31:0] model_read(input logic [31:0] a, output bit ok);
        logic [31:0] r;
        int base;
        ok = 1;
        r  = '0;
        if (!a[31]) begin
            base = int'({a[9:2], 2'b00});
            for (int k = 0; k < 4; k++) begin
                if (!m_vld[base + k]) ok = 0;
                r[8*k +: 8] = m_mem[base + k];
            end
        end else if (a[31:5] == 27'h400_0000) begin
            case (a[4:2])
                3'd0: r = {24'd0, m_gpio_out};
                3'd1: r = {24'd0, m_gin_prev};
                3'd2: r = m_cycle[31:0];
                3'd3: r = m_cycle[63:32];
                3'd4: r = m_cmp;
                3'd5: r = {29'd0, m_mis, m_en, m_pend};
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (model_live) begin
            logic [31:0] e;
            bit ok;
            e = model_read(Addr, ok);
            if (ok) chk("cycle_rdata", {32'd0, ReadData}, {32'd0, e});
            chk("cycle_gpio_out", {56'd0, gpio_out}, {56'd0, m_gpio_out});
            chk("cycle_irq", {63'd0, irq_timer}, {63'd0, m_pend & m_en});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
        Addr = a; WriteData = d; Storetype = t; MemWrite = 1'b1;
        step();
        MemWrite = 1'b0;
        $display("store type=%0d addr=0x%08h data=0x%08h", t, a, d);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        MemWrite = 1'b0;
        Addr = a;
        #1;
        chk(name, {32'd0, ReadData}, {32'd0, exp});
        $display("load addr=0x%08h data=0x%08h", a, ReadData);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rd_chk("cycle_lo_10", A_CYC_LO, 32'd10);
        rd_chk("cycle_hi_0", A_CYC_HI, 32'd0);

        // timer compare at 20, W1C lands on the match cycle
        wr(A_CMP, 32'd20, 2'b10);
        wr(A_STATUS, 32'h2, 2'b10);
        chk("irq_before_match", {63'd0, irq_timer}, 64'd0);
        n = 0;
        while (m_cycle[31:0] != 32'd20 && n < 100) begin step(); n++; end
        chk("timer_wait_bound", {63'd0, n >= 100}, 64'd0);
        wr(A_STATUS, 32'h3, 2'b10);
        rd_chk("status_pend_wins", A_STATUS, 32'h3);
        chk("irq_after_match", {63'd0, irq_timer}, 64'd1);
        wr(A_STATUS, 32'h1, 2'b10);
        rd_chk("status_cleared", A_STATUS, 32'h0);
        chk("irq_cleared", {63'd0, irq_timer}, 64'd0);

        // byte-lane merging
        wr(32'h10, 32'hDEADBEEF, 2'b10);
        wr(32'h11, 32'h00000055, 2'b00);
        wr(32'h12, 32'h0000A1B2, 2'b01);
        rd_chk("lane_merge", 32'h10, 32'hA1B255EF);
        wr(32'h20, 32'h0, 2'b10);
        wr(32'h20, 32'hFFFF1234, 2'b01);
        wr(32'h23, 32'hFFFFFF9A, 2'b00);
        rd_chk("sh_sb_mix", 32'h20, 32'h9A001234);
        rd_chk("alias_upper_bits", 32'h0000_0420, 32'h9A001234);

        // misaligned stores and narrow MMIO stores
        wr(32'h14, 32'h0BADF00D, 2'b10);
        wr(32'h16, 32'h11111111, 2'b10);
        rd_chk("misaligned_sw_ram", 32'h14, 32'h0BADF00D);
        rd_chk("misalign_status", A_STATUS, 32'h4);
        wr(A_STATUS, 32'h4, 2'b10);
        rd_chk("misalign_w1c", A_STATUS, 32'h0);
        wr(32'h21, 32'h7777, 2'b01);
        rd_chk("misaligned_sh_ram", 32'h20, 32'h9A001234);
        rd_chk("misalign_sh_status", A_STATUS, 32'h4);
        wr(A_STATUS, 32'h4, 2'b10);
        wr(A_GPIO_OUT, 32'h5A, 2'b00);
        chk("mmio_sb_dropped", {56'd0, gpio_out}, 64'd0);
        rd_chk("mmio_sb_status", A_STATUS, 32'h4);
        wr(A_STATUS, 32'h4, 2'b10);

        // same-word read during write shows old data
        Addr = 32'h14; WriteData = 32'hCAFEF00D; Storetype = 2'b10; MemWrite = 1'b1;
        #1;
        chk("rw_same_old", {32'd0, ReadData}, 64'h0BADF00D);
        step();
        MemWrite = 1'b0;
        rd_chk("rw_same_new", 32'h14, 32'hCAFEF00D);

        // GPIO
        gpio_in = 8'h3C;
        step();
        rd_chk("gpio_in_t1", A_GPIO_IN, 32'h0);
        step();
        rd_chk("gpio_in_t2", A_GPIO_IN, 32'h3C);
        wr(A_GPIO_OUT, 32'hA5, 2'b10);
        chk("gpio_out_a5", {56'd0, gpio_out}, 64'hA5);
        rd_chk("gpio_out_rd", A_GPIO_OUT, 32'hA5);

        // dropped writes and unmapped reads
        wr(32'hC000_0000, 32'h1234, 2'b10);
        wr(32'h10, 32'h0, 2'b11);
        rd_chk("st_none_dropped", 32'h10, 32'hA1B255EF);
        wr(A_CYC_LO, 32'h0, 2'b10);
        rd_chk("silent_drop_status", A_STATUS, 32'h0);
        rd_chk("unmapped_read", 32'hC000_0000, 32'h0);
        rd_chk("mmio_off6_read", 32'h8000_0018, 32'h0);
        rd_chk("mmio_past_window", 32'h8000_0020, 32'h0);

        // reset beats a concurrent store
        rst = 1'b1;
        wr(32'h10, 32'hFFFFFFFF, 2'b10);
        rst = 1'b0;
        rd_chk("rst_store_suppressed", 32'h10, 32'hA1B255EF);
        chk("rst_gpio_out", {56'd0, gpio_out}, 64'd0);
        rd_chk("rst_status", A_STATUS, 32'h0);

        // counter carry into HI and full 64-bit wrap
        force dut.cycle_reg = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut.cycle_reg;
        m_cycle = 64'h0000_0000_FFFF_FFFF;
        step();
        rd_chk("cycle_carry_hi", A_CYC_HI, 32'h1);
        rd_chk("cycle_carry_lo", A_CYC_LO, 32'h0);
        force dut.cycle_reg = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.cycle_reg;
        m_cycle = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        rd_chk("cycle_wrap_hi", A_CYC_HI, 32'h0);
        rd_chk("cycle_wrap_lo", A_CYC_LO, 32'h0);
        step();
        rd_chk("cycle_after_wrap", A_CYC_LO, 32'h1);

        step();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
